// File: rtl/ddc_pkg.sv
// Shared types and constants for the DDC strobe scheduler.
package ddc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRun
    } ddc_sched_state_t;

    localparam int unsigned DDC_RATE_MIN = 2;

endpackage

// File: rtl/ddc_strobe_gen.sv
// Input-sample divider and decimation counter producing the act/act_out strobes.
module ddc_strobe_gen
    import ddc_pkg::*;
#(
    parameter int unsigned RATE_WIDTH = 6,
    parameter int unsigned DIV_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    output logic                  act_o,
    output logic                  act_out_o,
    output logic                  wrap_o
);

    logic [DIV_WIDTH-1:0]  r_div_cnt, w_div_cnt_d;
    // Samples already issued in the current decimation.
    logic [RATE_WIDTH-1:0] r_dec_cnt, w_dec_cnt_d;
    logic                  r_act, w_act_d;
    logic                  r_act_out, w_act_out_d;
    logic                  w_tick;
    logic                  w_last;

    assign w_tick = (r_div_cnt == div_i);
    assign w_last = (r_dec_cnt >= rate_i - RATE_WIDTH'(1));

    // This edge issues act_out: the decimation boundary.
    assign wrap_o = en_i && !clear_i && w_tick && w_last;

    always_comb begin
        w_div_cnt_d = r_div_cnt;
        w_dec_cnt_d = r_dec_cnt;
        w_act_d     = 1'b0;
        w_act_out_d = 1'b0;
        if (!en_i) begin
            w_div_cnt_d = '0;
            w_dec_cnt_d = '0;
        end else if (clear_i) begin
            w_div_cnt_d = '0;
            w_dec_cnt_d = RATE_WIDTH'(1);
            w_act_d     = 1'b1;
        end else if (w_tick) begin
            w_div_cnt_d = '0;
            w_act_d     = 1'b1;
            w_act_out_d = w_last;
            w_dec_cnt_d = w_last ? '0 : r_dec_cnt + RATE_WIDTH'(1);
        end else begin
            w_div_cnt_d = r_div_cnt + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_div_cnt <= '0;
            r_dec_cnt <= '0;
            r_act     <= 1'b0;
            r_act_out <= 1'b0;
        end else begin
            r_div_cnt <= w_div_cnt_d;
            r_dec_cnt <= w_dec_cnt_d;
            r_act     <= w_act_d;
            r_act_out <= w_act_out_d;
        end
    end

    assign act_o     = r_act;
    assign act_out_o = r_act_out;

endmodule

// File: rtl/ddc_sched.sv
// DDC strobe scheduler: start/sync sequencing, boundary-aligned rate changes and
// suppression of DDC outputs while the CIC refills.
module ddc_sched
    import ddc_pkg::*;
#(
    parameter int unsigned CIC_MAXRATE = 50,
    parameter int unsigned CIC_N       = 5,
    parameter int unsigned SETTLE      = CIC_N,
    parameter int unsigned RATE_WIDTH  = $clog2(CIC_MAXRATE + 1),
    parameter int unsigned DIV_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  act_div_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic                  rate_ld_i,
    input  logic                  sync_i,
    input  logic                  ddc_val_i,
    output logic                  act_o,
    output logic                  act_out_o,
    output logic                  val_o,
    output logic                  rate_busy_o,
    output logic                  rate_err_o,
    output logic [RATE_WIDTH-1:0] rate_cur_o
);

    localparam int unsigned SetW = $clog2(SETTLE + 2);

    ddc_sched_state_t      r_state, w_state_d;
    logic [DIV_WIDTH-1:0]  r_div, w_div_d;
    logic [RATE_WIDTH-1:0] r_rate_cur, w_rate_d;
    logic [RATE_WIDTH-1:0] r_pend, w_pend_d, w_pend;
    logic [SetW-1:0]       r_set_cnt, w_set_d;
    logic                  r_busy, w_busy_d;
    logic                  r_err, w_err_d;
    logic                  r_val, w_val_d;
    logic                  w_ld_ok, w_ld_bad, w_pend_vld;
    logic                  w_clear, w_restart, w_settled, w_wrap;

    assign w_ld_ok  = rate_ld_i && (rate_i >= RATE_WIDTH'(DDC_RATE_MIN))
                      && (rate_i <= RATE_WIDTH'(CIC_MAXRATE));
    assign w_ld_bad = rate_ld_i && !w_ld_ok;

    // A legal load in this cycle is seen before sync, boundary and disable.
    assign w_pend_vld = w_ld_ok || r_busy;
    assign w_pend     = w_ld_ok ? rate_i : r_pend;

    assign w_clear   = en_i && ((r_state == StIdle) || sync_i);
    assign w_restart = en_i && (r_state != StIdle) && (sync_i || (w_wrap && w_pend_vld));
    assign w_settled = (r_set_cnt == SetW'(SETTLE))
                       || (ddc_val_i && ((r_set_cnt + SetW'(1)) == SetW'(SETTLE)));

    ddc_strobe_gen #(
        .RATE_WIDTH (RATE_WIDTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) u_strobe_gen (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (en_i),
        .clear_i   (w_clear),
        .rate_i    (r_rate_cur),
        .div_i     (r_div),
        .act_o     (act_o),
        .act_out_o (act_out_o),
        .wrap_o    (w_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (en_i) w_state_d = StSettle;
            end
            StSettle, StRun: begin
                if (!en_i) begin
                    w_state_d = StIdle;
                end else if (w_restart) begin
                    w_state_d = StSettle;
                end else if ((r_state == StSettle) && w_settled) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_rate_d = r_rate_cur;
        w_pend_d = r_pend;
        w_busy_d = r_busy;
        w_div_d  = r_div;
        w_set_d  = r_set_cnt;
        w_err_d  = w_ld_bad;
        w_val_d  = (r_state == StRun) && ddc_val_i;
        if (r_state == StIdle) begin
            if (w_ld_ok) w_rate_d = rate_i;
            if (en_i) begin
                w_div_d = act_div_i;
                w_set_d = '0;
            end
        end else if (!en_i || w_restart) begin
            if (w_pend_vld) w_rate_d = w_pend;
            w_busy_d = 1'b0;
            w_set_d  = '0;
            if (en_i && sync_i) w_div_d = act_div_i;
        end else begin
            w_pend_d = w_pend;
            w_busy_d = w_pend_vld;
            if ((r_state == StSettle) && ddc_val_i && (r_set_cnt != SetW'(SETTLE))) begin
                w_set_d = r_set_cnt + SetW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rate_cur <= RATE_WIDTH'(CIC_MAXRATE);
            r_pend     <= '0;
            r_busy     <= 1'b0;
            r_div      <= '0;
            r_set_cnt  <= '0;
            r_err      <= 1'b0;
            r_val      <= 1'b0;
        end else begin
            r_rate_cur <= w_rate_d;
            r_pend     <= w_pend_d;
            r_busy     <= w_busy_d;
            r_div      <= w_div_d;
            r_set_cnt  <= w_set_d;
            r_err      <= w_err_d;
            r_val      <= w_val_d;
        end
    end

    assign val_o       = r_val;
    assign rate_busy_o = r_busy;
    assign rate_err_o  = r_err;
    assign rate_cur_o  = r_rate_cur;

endmodule

// File: tb/tb_ddc_sched.sv
// Bench for ddc_sched: directed scenarios plus random traffic against an
// event-level reference model of the scheduler.
module tb_ddc_sched;

    localparam int MaxRate  = 50;
    localparam int SettleN  = 5;
    localparam int RateW    = 6;
    localparam int DivW     = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             en_i;
    logic [DivW-1:0]  act_div_i;
    logic [RateW-1:0] rate_i;
    logic             rate_ld_i;
    logic             sync_i;
    logic             ddc_val_i;
    logic             act_o;
    logic             act_out_o;
    logic             val_o;
    logic             rate_busy_o;
    logic             rate_err_o;
    logic [RateW-1:0] rate_cur_o;

    ddc_sched dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .act_div_i   (act_div_i),
        .rate_i      (rate_i),
        .rate_ld_i   (rate_ld_i),
        .sync_i      (sync_i),
        .ddc_val_i   (ddc_val_i),
        .act_o       (act_o),
        .act_out_o   (act_out_o),
        .val_o       (val_o),
        .rate_busy_o (rate_busy_o),
        .rate_err_o  (rate_err_o),
        .rate_cur_o  (rate_cur_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int q_ao[$];
    bit seen10;

    // Reference model: mode 0 idle, 1 settling, 2 running.
    int m_mode, m_rate, m_pend, m_period, m_phase, m_acts, m_seen;
    bit m_busy;
    bit e_act, e_ao, e_val, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_start();
        m_period = int'(act_div_i) + 1;
        m_phase  = 0;
        m_acts   = 1;
        m_seen   = 0;
        m_mode   = 1;
        e_act    = 1'b1;
    endtask

    task automatic model_edge();
        bit ld_ok;
        bit has_pend;
        int p;
        ld_ok    = rate_ld_i && (int'(rate_i) >= 2) && (int'(rate_i) <= MaxRate);
        e_err    = rate_ld_i && !ld_ok;
        e_val    = (m_mode == 2) && ddc_val_i;
        e_act    = 1'b0;
        e_ao     = 1'b0;
        has_pend = ld_ok || m_busy;
        p        = ld_ok ? int'(rate_i) : m_pend;
        if (!rst_n_i) begin
            m_mode = 0;
            m_rate = MaxRate;
            m_busy = 1'b0;
            m_pend = 0;
            e_err  = 1'b0;
            e_val  = 1'b0;
        end else if (m_mode == 0) begin
            if (ld_ok) m_rate = int'(rate_i);
            if (en_i) model_start();
        end else if (!en_i) begin
            if (has_pend) m_rate = p;
            m_busy = 1'b0;
            m_mode = 0;
        end else if (sync_i) begin
            if (has_pend) m_rate = p;
            m_busy = 1'b0;
            model_start();
        end else begin
            m_phase++;
            if (m_phase == m_period) begin
                m_phase = 0;
                e_act   = 1'b1;
                m_acts++;
                if (m_acts == m_rate) begin
                    e_ao   = 1'b1;
                    m_acts = 0;
                end
            end
            if (e_ao && has_pend) begin
                m_rate = p;
                m_busy = 1'b0;
                m_mode = 1;
                m_seen = 0;
            end else begin
                m_busy = has_pend;
                m_pend = p;
                if (m_mode == 1) begin
                    if (m_seen == SettleN) begin
                        m_mode = 2;
                    end else if (ddc_val_i) begin
                        m_seen++;
                        if (m_seen == SettleN) m_mode = 2;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
        cyc++;
        chk("act_o", act_o, e_act);
        chk("act_out_o", act_out_o, e_ao);
        chk("val_o", val_o, e_val);
        chk("rate_busy_o", rate_busy_o, m_busy);
        chk("rate_err_o", rate_err_o, e_err);
        chk("rate_cur_o", rate_cur_o, m_rate);
        if (act_out_o) q_ao.push_back(cyc);
        if (rate_cur_o == RateW'(10)) seen10 = 1'b1;
    endtask

    task automatic wait_ao(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!act_out_o && n < bound);
        chk("act_out_wait", act_out_o, 1);
    endtask

    task automatic load(input int r);
        rate_i    = RateW'(r);
        rate_ld_i = 1'b1;
        tick();
        rate_ld_i = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        act_div_i = '0;
        rate_i    = '0;
        rate_ld_i = 1'b0;
        sync_i    = 1'b0;
        ddc_val_i = 1'b0;
        seen10    = 1'b0;
        repeat (2) tick();
        chk("reset_rate", rate_cur_o, 50);

        // Full-rate input, reset decimation rate.
        rst_n_i = 1'b1;
        en_i    = 1'b1;
        tick();
        t0 = cyc;
        chk("start_act", act_o, 1);
        q_ao.delete();
        repeat (110) begin
            ddc_val_i = ($urandom_range(0, 3) == 0);
            tick();
        end
        chk("ao_count_r50", q_ao.size(), 2);
        if (q_ao.size() >= 2) begin
            chk("ao_first_r50", q_ao[0] - t0, 49);
            chk("ao_period_r50", q_ao[1] - q_ao[0], 50);
        end

        // Divided input, rate 4, settle discards the first five DDC outputs.
        en_i      = 1'b0;
        ddc_val_i = 1'b0;
        tick();
        load(4);
        chk("idle_load", rate_cur_o, 4);
        act_div_i = 4'd3;
        en_i      = 1'b1;
        tick();
        t0 = cyc;
        q_ao.delete();
        for (int k = 0; k < 6; k++) begin
            ddc_val_i = 1'b1;
            tick();
            chk("settle_val", val_o, (k == 5) ? 1 : 0);
            ddc_val_i = 1'b0;
            repeat (3) tick();
        end
        repeat (40) tick();
        if (q_ao.size() >= 2) begin
            chk("ao_first_r4", q_ao[0] - t0, 12);
            chk("ao_period_r4", q_ao[1] - q_ao[0], 16);
        end else begin
            chk("ao_count_r4", q_ao.size(), 2);
        end

        // Two loads before the boundary: last one wins.
        wait_ao(40);
        seen10 = 1'b0;
        load(10);
        chk("busy_after_ld", rate_busy_o, 1);
        tick();
        load(20);
        chk("busy_second_ld", rate_busy_o, 1);
        chk("rate_held", rate_cur_o, 4);
        wait_ao(40);
        chk("rate_applied", rate_cur_o, 20);
        chk("busy_cleared", rate_busy_o, 0);
        chk("no_rate10", seen10, 0);
        t0 = cyc;
        ddc_val_i = 1'b1;
        tick();
        ddc_val_i = 1'b0;
        chk("settle_restart", val_o, 0);
        wait_ao(120);
        chk("ao_period_r20", cyc - t0, 80);

        // Illegal rates.
        load(1);
        chk("err_low", rate_err_o, 1);
        chk("err_low_rate", rate_cur_o, 20);
        tick();
        chk("err_low_pulse", rate_err_o, 0);
        load(51);
        chk("err_high", rate_err_o, 1);
        chk("err_high_busy", rate_busy_o, 0);
        tick();
        chk("err_high_pulse", rate_err_o, 0);

        // Sync with seven samples into the decimation.
        wait_ao(100);
        act_div_i = 4'd1;
        n = 0;
        for (int k = 0; k < 40 && n < 7; k++) begin
            tick();
            if (act_o) n++;
        end
        chk("pre_sync_acts", n, 7);
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        chk("sync_act", act_o, 1);
        t0 = cyc;
        ddc_val_i = 1'b1;
        repeat (5) tick();
        chk("sync_settle_drop", val_o, 0);
        tick();
        chk("sync_settle_pass", val_o, 1);
        wait_ao(60);
        chk("sync_ao_delay", cyc - t0, 38);
        ddc_val_i = 1'b0;

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            en_i      = ($urandom_range(0, 99) != 0);
            sync_i    = ($urandom_range(0, 59) == 0);
            rate_ld_i = ($urandom_range(0, 24) == 0);
            rate_i    = ($urandom_range(0, 9) == 0) ? RateW'($urandom_range(0, 63))
                                                    : RateW'($urandom_range(2, 8));
            act_div_i = DivW'($urandom_range(0, 3));
            ddc_val_i = ($urandom_range(0, 2) == 0);
            tick();
        end

        // Disable coincident with sync and a legal load.
        en_i      = 1'b1;
        sync_i    = 1'b0;
        rate_ld_i = 1'b0;
        ddc_val_i = 1'b1;
        repeat (30) tick();
        en_i      = 1'b0;
        sync_i    = 1'b1;
        rate_i    = RateW'(8);
        rate_ld_i = 1'b1;
        tick();
        sync_i    = 1'b0;
        rate_ld_i = 1'b0;
        chk("dis_act", act_o, 0);
        chk("dis_act_out", act_out_o, 0);
        chk("dis_rate", rate_cur_o, 8);
        chk("dis_busy", rate_busy_o, 0);
        tick();

        // Reset mid-run with a rate pending.
        load(6);
        en_i      = 1'b1;
        act_div_i = 4'd0;
        repeat (20) tick();
        load(9);
        rst_n_i = 1'b0;
        tick();
        chk("rst_act", act_o, 0);
        chk("rst_act_out", act_out_o, 0);
        chk("rst_val", val_o, 0);
        chk("rst_busy", rate_busy_o, 0);
        chk("rst_err", rate_err_o, 0);
        chk("rst_rate", rate_cur_o, 50);
        rst_n_i = 1'b1;
        en_i    = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
